program_memory: RTL

Parametrised, writable successor to the fixed instruction ROM of the lab processor. It holds DEPTH instruction words of DATA_WIDTH bits. A sequential loader port fills it with a program at run time. Instructions are served through a registered fetch port with one-cycle latency. Sits between the program counter/fetch stage and an external program loader (UART/testbench). Reset erases the whole array to DEFAULT_WORD by a hardware sweep.

---
 rtl/program_memory.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/program_memory.sv
// Writable instruction store: hardware erase sweep on reset, sequential program
// loader, and a registered one-cycle fetch port that is only served while idle.
module program_memory #(
  parameter int                    DATA_WIDTH   = 28,
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DEPTH        = 256,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = DATA_WIDTH'(28'h00000AA)
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [ADDR_WIDTH-1:0]    iAddress,
  input  logic                     iFetchValid,
  output logic [DATA_WIDTH-1:0]    oInstruction,
  output logic                     oInstructionValid,
  output logic                     oFault,
  input  logic                     iLoadStart,
  input  logic [DATA_WIDTH-1:0]    iLoadData,
  input  logic                     iLoadValid,
  input  logic                     iLoadLast,
  output logic                     oLoadReady,
  output logic                     oLoadDone,
  output logic [$clog2(DEPTH):0]   oLoadCount,
  output logic                     oBusy,
  output logic [1:0]               oDebugState
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0]    PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_RUN   = 2'd1,
    S_LOAD  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  instr_valid_q, instr_valid_d;
  logic                  fault_q, fault_d;
  logic                  load_ready_q, load_ready_d;
  logic                  load_done_q, load_done_d;
  logic [CNT_W-1:0]      load_count_q, load_count_d;
  logic                  busy_q, busy_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  mem_we;
  logic [PTR_W-1:0]      mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  addr_in_range;
  logic                  load_accept;

  // Loader handshake: a word transfers on every rising edge where
  // iLoadValid && oLoadReady; iLoadLast is only meaningful on such an edge.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    fault_d       = 1'b0;
    load_done_d   = 1'b0;
    load_count_d  = load_count_q;
    mem_we        = 1'b0;
    mem_waddr     = ptr_q;
    mem_wdata     = DEFAULT_WORD;
    addr_in_range = ({1'b0, iAddress} < DEPTH_EXT);
    load_accept   = iLoadValid && load_ready_q;

    if (iFetchValid) begin
      if (state_q == S_RUN) begin
        instr_valid_d = 1'b1;
        if (addr_in_range) begin
          instr_d = mem_q[iAddress[PTR_W-1:0]];
        end else begin
          instr_d = DEFAULT_WORD;
          fault_d = 1'b1;
        end
      end else begin
        instr_d = DEFAULT_WORD;
      end
    end

    case (state_q)
      S_CLEAR: begin
        mem_we = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == PTR_LAST) begin
          state_d = S_RUN;
          ptr_d   = '0;
        end
      end
      S_RUN: begin
        if (iLoadStart) begin
          state_d = S_LOAD;
          ptr_d   = '0;
        end
      end
      S_LOAD: begin
        if (load_accept) begin
          mem_we    = 1'b1;
          mem_wdata = iLoadData;
          ptr_d     = ptr_q + 1'b1;
          // The array end terminates the load even without iLoadLast.
          if (iLoadLast || (ptr_q == PTR_LAST)) begin
            state_d      = S_RUN;
            ptr_d        = '0;
            load_done_d  = 1'b1;
            load_count_d = {1'b0, ptr_q} + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_CLEAR;
        ptr_d   = '0;
      end
    endcase

    if (Reset) begin
      mem_we = 1'b0;
    end

    load_ready_d = (state_d == S_LOAD);
    busy_d       = (state_d != S_RUN);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= S_CLEAR;
      ptr_q         <= '0;
      instr_q       <= DEFAULT_WORD;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      load_ready_q  <= 1'b0;
      load_done_q   <= 1'b0;
      load_count_q  <= '0;
      busy_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
      load_ready_q  <= load_ready_d;
      load_done_q   <= load_done_d;
      load_count_q  <= load_count_d;
      busy_q        <= busy_d;
    end
  end

  // The array has no reset of its own; the CLEAR sweep erases it.
  always_ff @(posedge Clock) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign oInstruction      = instr_q;
  assign oInstructionValid = instr_valid_q;
  assign oFault            = fault_q;
  assign oLoadReady        = load_ready_q;
  assign oLoadDone         = load_done_q;
  assign oLoadCount        = load_count_q;
  assign oBusy             = busy_q;
  assign oDebugState       = state_q;

endmodule
